// File: rtl/pm_otf_converter_if.sv
// Handshake bundle between the online-multiplier product path and the
// on-the-fly converter: start/z_in in, busy/done/q back.
interface pm_otf_converter_if #(
    parameter int N = 4
);
    logic             start;
    logic [4*N-1:0]   z_in;
    logic             busy;
    logic             done;
    logic [2*N:0]     q;

    // Requester side: issues start with a product word, watches the result.
    modport master (
        output start,
        output z_in,
        input  busy,
        input  done,
        input  q
    );

    // Converter side.
    modport slave (
        input  start,
        input  z_in,
        output busy,
        output done,
        output q
    );
endinterface

// File: rtl/pm_otf_converter.sv
// On-the-fly conversion of a 2N-digit borrow-save product word (MSD first,
// one digit per clock) into a 2N+1 bit two's-complement integer, using the
// classic Q / QM register pair where QM always equals Q - 1.
module pm_otf_converter #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pm_otf_converter_if.slave     bus
);
    localparam int ZW    = 4 * N;
    localparam int QW    = 2 * N + 1;
    localparam int CNT_W = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [ZW-1:0]      shreg_reg;
    logic [QW-1:0]      q_acc_reg;
    logic [QW-1:0]      qm_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [QW-1:0]      q_out_reg;

    logic [1:0]         msd;
    logic [QW-1:0]      q_acc_next;
    logic [QW-1:0]      qm_next;

    assign msd = shreg_reg[ZW-1:ZW-2];

    // Digit append for the current MSD; the bit shifted out of the top of
    // Q/QM is dropped, which is safe because |Z| < 2^(2N).
    always_comb begin
        q_acc_next = {q_acc_reg[QW-2:0], 1'b0};
        qm_next    = {qm_reg[QW-2:0], 1'b1};
        case (msd)
            2'b10: begin // +1
                q_acc_next = {q_acc_reg[QW-2:0], 1'b1};
                qm_next    = {q_acc_reg[QW-2:0], 1'b0};
            end
            2'b01: begin // -1
                q_acc_next = {qm_reg[QW-2:0], 1'b1};
                qm_next    = {qm_reg[QW-2:0], 1'b0};
            end
            default: begin // 00 and 11 both encode zero
                q_acc_next = {q_acc_reg[QW-2:0], 1'b0};
                qm_next    = {qm_reg[QW-2:0], 1'b1};
            end
        endcase
    end

    // Control FSM with datapath; all outputs registered. A start seen in
    // DONE reloads immediately so back-to-back words take 2N+1 cycles each.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            q_acc_reg <= '0;
            qm_reg    <= '1;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            q_out_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        shreg_reg <= bus.z_in;
                        q_acc_reg <= '0;
                        qm_reg    <= '1;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CONV;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    shreg_reg <= {shreg_reg[ZW-3:0], 2'b00};
                    q_acc_reg <= q_acc_next;
                    qm_reg    <= qm_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        q_out_reg <= q_acc_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.q    = q_out_reg;
endmodule

// File: tb/tb_pm_otf_converter.sv
// Directed bench for pm_otf_converter (N=4): single conversions, ignored
// mid-conversion start, back-to-back operation and mid-conversion reset.
module tb_pm_otf_converter;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    pm_otf_converter_if #(.N(N)) bus ();

    pm_otf_converter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset for two cycles, then check all outputs are at reset values.
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.z_in = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        vectors++;
        if (bus.q !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_q got %h want 000", bus.q);
        end
        rst = 1'b0;
        $display("reset: busy=%b done=%b q=%h", bus.busy, bus.done, bus.q);
    endtask

    // One conversion from a start pulse; optionally pulse start mid-CONV.
    task automatic test_conv(input string name, input logic [15:0] z,
                             input logic [8:0] exp_q, input bit mid_start);
        @(negedge clk);
        bus.start = 1'b1;
        bus.z_in  = z;
        @(posedge clk);              // E0
        #1;
        bus.start = 1'b0;
        bus.z_in  = 16'h0000;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy_e0 got %b want 1", name, bus.busy);
        end
        for (int k = 1; k <= 2 * N; k++) begin
            @(posedge clk);
            #1;
            bus.start = (mid_start && k == 3) ? 1'b1 : 1'b0;
            if (mid_start && k == 3) bus.z_in = 16'h5555;
            if (k < 2 * N) begin
                vectors++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s_cycle%0d got done=%b busy=%b want done=0 busy=1",
                             name, k, bus.done, bus.busy);
                end
            end else begin
                vectors++;
                if (bus.done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s_done got %b want 1", name, bus.done);
                end
                vectors++;
                if (bus.q !== exp_q) begin
                    miscompares++;
                    $display("FAIL %s_q got %h want %h", name, bus.q, exp_q);
                end
                vectors++;
                if (bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_busy_end got %b want 0", name, bus.busy);
                end
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
        vectors++;
        if (bus.q !== exp_q) begin
            miscompares++;
            $display("FAIL %s_q_hold got %h want %h", name, bus.q, exp_q);
        end
        $display("%s: z_in=%h q=%h (expect %h)", name, z, bus.q, exp_q);
    endtask

    // start held high: AAAA accepted at E0, 0001 accepted at E9 (DONE cycle).
    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1;
        bus.z_in  = 16'hAAAA;
        @(posedge clk);              // E0
        #1;
        bus.z_in = 16'h0001;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                vectors++;
                if (bus.done !== 1'b1 || bus.q !== 9'h0FF) begin
                    miscompares++;
                    $display("FAIL b2b_first got done=%b q=%h want 1 0ff", bus.done, bus.q);
                end
            end else if (k == 9) begin
                vectors++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_reload got done=%b busy=%b want 0 1", bus.done, bus.busy);
                end
            end else if (k == 17) begin
                vectors++;
                if (bus.done !== 1'b1 || bus.q !== 9'h1FF) begin
                    miscompares++;
                    $display("FAIL b2b_second got done=%b q=%h want 1 1ff", bus.done, bus.q);
                end
                bus.start = 1'b0;
            end else if (k == 18) begin
                vectors++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_idle got done=%b busy=%b want 0 0", bus.done, bus.busy);
                end
            end else if (k < 17) begin
                vectors++;
                if (bus.done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_cycle%0d done got %b want 0", k, bus.done);
                end
            end
        end
        $display("back_to_back: final q=%h", bus.q);
    endtask

    // Reset asserted mid-conversion aborts it with no done pulse.
    task automatic test_reset_mid_conv();
        @(negedge clk);
        bus.start = 1'b1;
        bus.z_in  = 16'hAAAA;
        @(posedge clk);              // E0
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 9'h000) begin
            miscompares++;
            $display("FAIL rst_mid got busy=%b done=%b q=%h want 0 0 000",
                     bus.busy, bus.done, bus.q);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_quiet%0d got done=%b busy=%b want 0 0",
                         k, bus.done, bus.busy);
            end
        end
        $display("reset_mid_conv: busy=%b q=%h", bus.busy, bus.q);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_conv("all_plus", 16'hAAAA, 9'h0FF, 1'b0);
        test_conv("all_minus", 16'h5555, 9'h101, 1'b0);
        test_conv("d7p_d6m", 16'h9000, 9'h040, 1'b0);
        test_conv("d0m", 16'h0001, 9'h1FF, 1'b0);
        test_conv("all_11", 16'hFFFF, 9'h000, 1'b0);
        test_conv("mid_start", 16'hAAAA, 9'h0FF, 1'b1);
        test_back_to_back();
        test_reset_mid_conv();
        test_conv("after_rst", 16'h9000, 9'h040, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pm_otf_converter.md
# pm_otf_converter

Downstream stage of the sequential parallel online multiplier. Takes the multiplier's redundant borrow-save product word, which holds 2N signed digits. Converts it MSD-first, one digit per clock, into a conventional two's-complement integer using on-the-fly conversion with Q/QM registers. The result is registered and flagged with a one-cycle done pulse.

## Interface
- N, default 4: digits per multiplier operand.
  - Operand word is WL = 2N bits.
  - Product word is 2·WL = 4N bits (2N digits).
  - Result is 2N+1 bits.
- clk  in  1: single clock; all state changes on the rising edge.
- rst  in  1: reset, synchronous and active-high.
- start  in  1: request conversion of z_in; sampled on the rising edge.
- z_in  in  4N: product word from the multiplier. Digit i (i = 0..2N-1) is bits [2i+1:2i] = {p,n}, with value p−n.
  - 10 = +1, 01 = −1, 00 = 0, 11 = 0.
  - Digit 2N−1 is the MSD.
- busy  out  1: high while a conversion is in progress.
- done  out  1: one-cycle pulse; q has just been updated.
- q  out  2N+1: two's-complement result, Z = Σ d_i·2^i, range ±(2^2N − 1).

## Operation
- States:
  - IDLE: waiting for start.
  - CONV: shifting digits, 2N cycles.
  - DONE: one cycle, done=1.
- IDLE, start=1: load z_in into the digit shift register, set Q ← 0, QM ← all ones (−1), cnt ← 0, go to CONV.
- IDLE, start=0: hold.
- CONV, each cycle: take the MSD d from the shift register, shift the register left by one digit (2 bits), cnt ← cnt+1. Update:
  - d=+1: Q ← {Q,1}, QM ← {Q,0}.
  - d=0: Q ← {Q,0}, QM ← {QM,1}.
  - d=−1: Q ← {QM,1}, QM ← {QM,0}.
  - Invariant: QM = Q − 1 at all times.
- Q and QM are 2N+1 bits wide. They shift left, and the MSB shifted out is discarded. The final Q is exact because |Z| < 2^2N.
- CONV, when cnt reaches 2N−1 (last digit): write the updated Q into q and go to DONE.
- DONE: done=1.
  - start=1: reload exactly as from IDLE, go to CONV. This gives back-to-back operation.
  - start=0: go to IDLE.
- start in CONV is ignored. z_in is don't-care except on the edge where start is accepted.
- q holds its value until the next completion or reset.
- cnt is ⌈log2(2N)⌉ bits.

## Timing
- Reset: state=IDLE, busy=0, done=0, q=0, Q=0, QM=all ones, cnt=0, shift register=0.
- start accepted at edge E0.
  - busy=1 from after E0 through E2N.
  - Digits are consumed at edges E1..E2N.
  - q and done update at E2N; done=1 for exactly one cycle, then falls at E2N+1.
- Latency start→done is 2N clocks (8 for N=4).
- Throughput: one conversion per 2N+1 cycles when start is held high. The reload happens in the DONE cycle.
- busy=0 in IDLE and DONE.
- rst=1 in any state, including mid-CONV: on that edge, return to reset values. The conversion is aborted and no done is produced.
- rst has priority over start on the same edge.

## Test plan
- N=4, z_in=16'hAAAA (all +1), start pulse → done exactly 8 cycles after the start edge, q=9'h0FF (255), busy high for 8 cycles.
- z_in=16'h5555 (all −1) → q=9'h101 (−255).
- z_in=16'h9000 (d7=+1, d6=−1) → q=9'h040 (64).
- z_in=16'h0001 (d0=−1) → q=9'h1FF (−1).
- z_in=16'hFFFF (all 11) → q=0.
- start held high with 16'hAAAA then 16'h0001 presented at the accept edges → q=9'h0FF, then q=9'h1FF nine cycles later. A start pulsed mid-CONV is ignored.
- Reset mid-conversion: start with 16'hAAAA, assert rst at cycle 4 → busy=0, q=0, no done pulse. A new start afterwards with 16'h9000 yields q=9'h040.
